cdb_arbiter: RTL and testbench

//  Transmit end of the common data bus: collects completed results from the ALU, MUL and LS units,

---
 rtl/cdb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_cdb_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: transmit end of the common data bus.
// Three result sources (0=ALU, 1=MUL, 2=LS) each feed a small FIFO. One
// non-empty FIFO is granted per cycle in round-robin order, and the winner is
// registered onto the cdb broadcast. branch_flush discards every buffered and
// pending result.
//
// Packet layout (CDB_W = 77 bits, MSB first):
//   [76]    cdb_valid       (ignored on the source packets)
//   [75:70] preg_index
//   [69:65] areg_index
//   [64:33] result
//   [32]    jalr_flag
//   [31:0]  jalr_return_pc
//
// Optional feature macro: CDB_BYPASS_EN. When it is defined, a source whose
// FIFO is empty may compete with its incoming packet in the same cycle and, if
// it wins, go straight to the cdb register (1-cycle latency).
//
// Handshake: a packet is taken at posedge when x_valid && x_ready. x_ready is
// a function of the registered FIFO count only, so a full FIFO never accepts
// in the same cycle that it pops; the source must hold its packet until taken.
module cdb_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int NUM_SRC    = 3,
    localparam int CDB_W     = 77
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch_flush,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [CDB_W-1:0] alu_pkt,
    input  logic             mul_valid,
    output logic             mul_ready,
    input  logic [CDB_W-1:0] mul_pkt,
    input  logic             ls_valid,
    output logic             ls_ready,
    input  logic [CDB_W-1:0] ls_pkt,
    output logic [CDB_W-1:0] cdb
);

    localparam int ENT_W     = CDB_W - 1;
    localparam int VALID_BIT = CDB_W - 1;
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [NUM_SRC-1:0] src_valid;
    logic [NUM_SRC-1:0] src_ready;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] byp;
    logic [NUM_SRC-1:0] enq;
    logic [NUM_SRC-1:0] deq;
    logic [ENT_W-1:0]   src_pkt [NUM_SRC];

    logic [ENT_W-1:0]   mem   [NUM_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0]   head  [NUM_SRC];
    logic [PTR_W-1:0]   tail  [NUM_SRC];
    logic [CNT_W-1:0]   count [NUM_SRC];

    logic [1:0]         rr_ptr;
    logic [1:0]         grant_idx;
    logic [1:0]         scan_idx;
    logic               grant_any;
    logic [ENT_W-1:0]   grant_pkt;

    // The valid bit of a source packet carries no meaning and is dropped.
    logic unused_src_valid_bits;
    assign unused_src_valid_bits = ^{alu_pkt[VALID_BIT], mul_pkt[VALID_BIT], ls_pkt[VALID_BIT]};

    function automatic logic [1:0] inc_mod3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign src_valid  = {ls_valid, mul_valid, alu_valid};
    assign src_pkt[0] = alu_pkt[ENT_W-1:0];
    assign src_pkt[1] = mul_pkt[ENT_W-1:0];
    assign src_pkt[2] = ls_pkt[ENT_W-1:0];
    assign alu_ready  = src_ready[0];
    assign mul_ready  = src_ready[1];
    assign ls_ready   = src_ready[2];

    // Readiness from registered occupancy only; accepted pushes and candidates.
    always_comb begin
        src_ready = '0;
        push      = '0;
        cand      = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            src_ready[s] = (count[s] != FULL_CNT);
            push[s]      = src_valid[s] && src_ready[s];
`ifdef CDB_BYPASS_EN
            cand[s]      = (count[s] != '0) || push[s];
`else
            cand[s]      = (count[s] != '0);
`endif
        end
    end

    // Round-robin scan starting at rr_ptr; first candidate found wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = 2'd0;
        scan_idx  = rr_ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!grant_any && cand[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
            scan_idx = inc_mod3(scan_idx);
        end
    end

    // Per-source pop/enqueue decisions and the winning packet.
    always_comb begin
        byp       = '0;
        enq       = '0;
        deq       = '0;
        grant_pkt = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
`ifdef CDB_BYPASS_EN
            // Winner with an empty FIFO is its own incoming packet.
            byp[s] = grant_any && (grant_idx == 2'(s)) && (count[s] == '0);
`endif
            deq[s] = grant_any && (grant_idx == 2'(s)) && !byp[s];
            enq[s] = push[s] && !byp[s];
            if (grant_any && (grant_idx == 2'(s))) begin
                grant_pkt = byp[s] ? src_pkt[s] : mem[s][head[s]];
            end
        end
    end

    // FIFO storage writes; content needs no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (!rst && !branch_flush) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (enq[s]) begin
                    mem[s][tail[s]] <= src_pkt[s];
                end
            end
        end
    end

    // FIFO pointers and occupancy; flush empties every FIFO.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (rst || branch_flush) begin
                head[s]  <= '0;
                tail[s]  <= '0;
                count[s] <= '0;
            end else begin
                if (enq[s]) tail[s] <= tail[s] + 1'b1;
                if (deq[s]) head[s] <= head[s] + 1'b1;
                case ({enq[s], deq[s]})
                    2'b10:   count[s] <= count[s] + 1'b1;
                    2'b01:   count[s] <= count[s] - 1'b1;
                    default: count[s] <= count[s];
                endcase
            end
        end
    end

    // Broadcast register and round-robin pointer; flush keeps rr_ptr.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb    <= '0;
            rr_ptr <= 2'd0;
        end else if (branch_flush) begin
            cdb[VALID_BIT] <= 1'b0;
        end else if (grant_any) begin
            cdb    <= {1'b1, grant_pkt};
            rr_ptr <= inc_mod3(grant_idx);
        end else begin
            cdb[VALID_BIT] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-source send queues feed a valid/ready
// driver, every broadcast is collected in order, and the collected stream is
// compared against hand-worked expected packets.
module tb_cdb_arbiter;

    localparam int CDB_W = 77;
    localparam int ENT_W = 76;

    logic             clk = 1'b0;
    logic             rst;
    logic             branch_flush;
    logic             alu_valid, mul_valid, ls_valid;
    logic             alu_ready, mul_ready, ls_ready;
    logic [CDB_W-1:0] alu_pkt, mul_pkt, ls_pkt;
    logic [CDB_W-1:0] cdb;

    int checks   = 0;
    int failures = 0;
    int accepted = 0;

    logic [ENT_W-1:0] send_q [3][$];
    logic [ENT_W-1:0] got_q  [$];

    cdb_arbiter #(.FIFO_DEPTH(2), .NUM_SRC(3)) dut (
        .clk(clk), .rst(rst), .branch_flush(branch_flush),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_pkt(alu_pkt),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_pkt(mul_pkt),
        .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_pkt(ls_pkt),
        .cdb(cdb)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [ENT_W-1:0] mk(input logic [5:0] preg, input logic [4:0] areg,
                                            input logic [31:0] res, input logic jf,
                                            input logic [31:0] jpc);
        return {preg, areg, res, jf, jpc};
    endfunction

    // Standard tagged packet: source s, sequence k.
    function automatic logic [ENT_W-1:0] tag_pkt(input int s, input int k);
        return mk(6'(s * 10 + k), 5'(s), 32'h100 * 32'(s) + 32'(k), 1'b0, 32'h0);
    endfunction

    // One clock: drive heads of enabled send queues, retire accepted ones,
    // collect the broadcast seen after the edge.
    task automatic tick(input logic [2:0] en);
        logic [2:0]       v;
        logic [2:0]       acc;
        logic [ENT_W-1:0] drv [3];
        for (int s = 0; s < 3; s++) begin
            v[s]   = en[s] && (send_q[s].size() > 0);
            drv[s] = '0;
            if (v[s]) drv[s] = send_q[s][0];
        end
        alu_valid = v[0]; alu_pkt = {1'b0, drv[0]};
        mul_valid = v[1]; mul_pkt = {1'b0, drv[1]};
        ls_valid  = v[2]; ls_pkt  = {1'b0, drv[2]};
        acc = v & {ls_ready, mul_ready, alu_ready};
        @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            if (acc[s]) begin
                void'(send_q[s].pop_front());
                accepted++;
            end
        end
        if (cdb[CDB_W-1]) got_q.push_back(cdb[ENT_W-1:0]);
    endtask

    task automatic clear_all();
        for (int s = 0; s < 3; s++) send_q[s].delete();
        got_q.delete();
        accepted = 0;
    endtask

    task automatic do_reset();
        clear_all();
        rst = 1'b1;
        tick(3'b000);
        tick(3'b000);
        rst = 1'b0;
        got_q.delete();
    endtask

    logic [2:0]       exp_rdy [9];
    logic [ENT_W-1:0] pj, pz, p2;
    int               n_before;
    int               mi;

    initial begin
        rst = 1'b1;
        branch_flush = 1'b0;
        alu_valid = 1'b0; mul_valid = 1'b0; ls_valid = 1'b0;
        alu_pkt = '0; mul_pkt = '0; ls_pkt = '0;
        exp_rdy = '{3'b111, 3'b111, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

        // Test 1: reset state and idle cycles.
        do_reset();
        check("t1_reset_cdb", cdb, '0);
        for (int c = 0; c < 5; c++) begin
            tick(3'b000);
            check("t1_idle_valid", cdb[CDB_W-1], 1'b0);
            check("t1_idle_ready", {ls_ready, mul_ready, alu_ready}, 3'b111);
        end

        // Test 2: single ALU push latency and field contents.
        do_reset();
        p2 = mk(6'd7, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0);
        send_q[0].push_back(p2);
        tick(3'b001);
`ifdef CDB_BYPASS_EN
        check("t2_edge_n", cdb, {1'b1, p2});
        tick(3'b000);
        check("t2_after", cdb[CDB_W-1], 1'b0);
`else
        check("t2_edge_n", cdb[CDB_W-1], 1'b0);
        tick(3'b000);
        check("t2_edge_n1", cdb, {1'b1, p2});
        tick(3'b000);
        check("t2_after", cdb[CDB_W-1], 1'b0);
`endif

        // Test 3: full contention for 9 cycles, round-robin order.
        do_reset();
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 10; k++) send_q[s].push_back(tag_pkt(s, k));
        for (int c = 0; c < 9; c++) begin
`ifndef CDB_BYPASS_EN
            check("t3_ready", {ls_ready, mul_ready, alu_ready}, exp_rdy[c]);
`endif
            tick(3'b111);
        end
        for (int s = 0; s < 3; s++) send_q[s].delete();
        repeat (6) tick(3'b000);
`ifndef CDB_BYPASS_EN
        check("t3_accepted", 128'(accepted), 128'(13));
`endif
        check("t3_count", 128'(got_q.size()), 128'(accepted));
        for (int i = 0; i < got_q.size(); i++)
            check("t3_order", got_q[i], tag_pkt(i % 3, i / 3));

        // Test 4: MUL FIFO full, third packet held until a slot frees.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            send_q[0].push_back(tag_pkt(0, k));
            send_q[2].push_back(tag_pkt(2, k));
        end
        for (int k = 0; k < 3; k++) send_q[1].push_back(tag_pkt(1, k));
        tick(3'b111);
        tick(3'b111);
`ifndef CDB_BYPASS_EN
        check("t4_mul_full", mul_ready, 1'b0);
`endif
        tick(3'b010);
`ifndef CDB_BYPASS_EN
        check("t4_third_held", 128'(send_q[1].size()), 128'(1));
        check("t4_mul_free", mul_ready, 1'b1);
`endif
        tick(3'b010);
        tick(3'b010);
        check("t4_mul_sent", 128'(send_q[1].size()), 128'(0));
        repeat (6) tick(3'b000);
        check("t4_total", 128'(got_q.size()), 128'(7));
        mi = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            if (got_q[i][69:65] == 5'd1) begin
                check("t4_mul_order", got_q[i], tag_pkt(1, mi));
                mi++;
            end
        end
        check("t4_mul_count", 128'(mi), 128'(3));

        // Test 5: flush with buffered entries; nothing flushed ever appears.
        do_reset();
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 4; k++) send_q[s].push_back(tag_pkt(s, k));
        tick(3'b111);
        tick(3'b111);
        tick(3'b111);
        branch_flush = 1'b1;
        tick(3'b111);
        branch_flush = 1'b0;
        check("t5_flush_valid", cdb[CDB_W-1], 1'b0);
        check("t5_flush_ready", {ls_ready, mul_ready, alu_ready}, 3'b111);
        n_before = got_q.size();
`ifndef CDB_BYPASS_EN
        check("t5_pre_flush_cnt", 128'(n_before), 128'(2));
`endif
        for (int s = 0; s < 3; s++) send_q[s].delete();
        repeat (6) tick(3'b000);
        check("t5_no_leak", 128'(got_q.size()), 128'(n_before));
`ifndef CDB_BYPASS_EN
        // rr_ptr survives the flush: after granting MUL it points at LS.
        for (int s = 0; s < 3; s++) send_q[s].push_back(tag_pkt(s, 9));
        tick(3'b111);
        tick(3'b000);
        check("t5_rr_kept", cdb, {1'b1, tag_pkt(2, 9)});
`endif

        // Test 6: jalr and preg 0 packets forwarded bit-exact.
        do_reset();
        pj = mk(6'd12, 5'd1, 32'h0000_1234, 1'b1, 32'h0000_0060);
        pz = mk(6'd0, 5'd3, 32'hCAFE_F00D, 1'b0, 32'h0);
        send_q[2].push_back(pj);
        send_q[2].push_back(pz);
        tick(3'b100);
        tick(3'b100);
        repeat (4) tick(3'b000);
        check("t6_count", 128'(got_q.size()), 128'(2));
        if (got_q.size() == 2) begin
            check("t6_jalr", got_q[0], pj);
            check("t6_preg0", got_q[1], pz);
        end

        // Test 7: reset mid-stream discards all content.
        do_reset();
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < 3; k++) send_q[s].push_back(tag_pkt(s, k));
        tick(3'b111);
        tick(3'b111);
        rst = 1'b1;
        tick(3'b000);
        rst = 1'b0;
        check("t7_rst_cdb", cdb, '0);
        check("t7_rst_ready", {ls_ready, mul_ready, alu_ready}, 3'b111);
        n_before = got_q.size();
        repeat (5) tick(3'b000);
        check("t7_no_leak", 128'(got_q.size()), 128'(n_before));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
